axi_lock_burst_client: RTL and testbench

//  Requester side of the AXI4 write/read lock handshake. One instance per direction (write or read channel).

---
 rtl/axi_lock_burst_client_if.sv | 23 ++
 rtl/axi_lock_burst_client.sv | 94 +++++++++
 tb/tb_axi_lock_burst_client.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lock_burst_client_if.sv
// Handshake bundle between a lock/burst client, the lock arbiter and the AXI burst engine.
// The master side is the client. The slave side is the arbiter together with the burst engine.
interface axi_lock_burst_client_if #(
  parameter int CNT_W = 8
);
  logic             pend_self;
  logic             lock_req;
  logic             lock_done;
  logic             burst_start;
  logic [CNT_W-1:0] burst_len;
  logic             beat_fire;
  logic             burst_end;

  modport master (
    input  pend_self, beat_fire, burst_end,
    output lock_req, lock_done, burst_start, burst_len
  );

  modport slave (
    output pend_self, beat_fire, burst_end,
    input  lock_req, lock_done, burst_start, burst_len
  );
endinterface

// File: rtl/axi_lock_burst_client.sv
// Requester side of the write/read lock handshake. It decides when a FIFO burst is due,
// acquires the lock, launches the burst, counts the data beats and releases the lock.
module axi_lock_burst_client #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         flush,
  input  logic [CNT_W-1:0]             fifo_level,
  axi_lock_burst_client_if.master      bus,
  output logic                         busy,
  output logic                         err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GNT,
    START,
    XFER,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state, next_state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] final_cnt;
  logic             start_ok;
  logic             beat_ok;
  logic             extra_beat;
  logic             count_bad;

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    start_ok   = enable && ((fifo_level >= FULL_LEN) || (flush && (fifo_level != '0)));
    beat_ok    = bus.beat_fire && (beat_cnt != len_q) && (beat_cnt != CNT_MAX);
    extra_beat = bus.beat_fire && (beat_cnt == len_q);
    final_cnt  = beat_ok ? beat_cnt + CNT_W'(1) : beat_cnt;
    count_bad  = bus.burst_end && (final_cnt != len_q);

    unique case (state)
      IDLE:    if (start_ok) next_state = REQ;
      REQ:     next_state = GNT;
      GNT:     if (!bus.pend_self) next_state = START;
      START:   next_state = XFER;
      XFER:    if (bus.burst_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so that each one is a flop aligned with the state it belongs to.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples its pre-edge values.
  always_ff @(posedge clock) begin
    // NOTE: the reset is synchronous and clears every flop, the counter and the sticky err included.
    if (rst) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      len_q           <= '0;
      err             <= 1'b0;
      busy            <= 1'b0;
      bus.lock_req    <= 1'b0;
      bus.lock_done   <= 1'b0;
      bus.burst_start <= 1'b0;
    end else begin
      state           <= next_state;
      busy            <= (next_state != IDLE);
      bus.lock_req    <= (next_state inside {REQ, GNT, START, XFER});
      bus.lock_done   <= (next_state == DONE);
      bus.burst_start <= (next_state == START);

      if ((state == IDLE) && start_ok)
        len_q <= (fifo_level < FULL_LEN) ? fifo_level : FULL_LEN;

      if (state == START)
        beat_cnt <= '0;
      else if ((state == XFER) && beat_ok)
        beat_cnt <= beat_cnt + CNT_W'(1);

      // A beat beyond burst_len is dropped from the count but still flags the burst as bad.
      if ((state == XFER) && (extra_beat || count_bad))
        err <= 1'b1;
    end
  end

  assign bus.burst_len = len_q;

endmodule

// File: tb/tb_axi_lock_burst_client.sv
// Directed bench for axi_lock_burst_client: two instances checked against a phase-level model,
// plus a small behavioural arbiter that exercises the write/read alternation.
module tb_axi_lock_burst_client;
  localparam int BL = 16;
  localparam int CW = 8;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_WAIT  = 2;
  localparam int P_START = 3;
  localparam int P_XFER  = 4;
  localparam int P_DONE  = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst;
  logic          enable     [2];
  logic          flush      [2];
  logic [CW-1:0] fifo_level [2];
  logic          man_pend   [2];
  logic          bf         [2];
  logic          be         [2];
  logic          arb_mode;

  logic          busy        [2];
  logic          err         [2];
  logic          lock_req    [2];
  logic          lock_done   [2];
  logic          burst_start [2];
  logic [CW-1:0] burst_len   [2];
  logic          pend_in     [2];

  int owner      = -1;
  int last_owner = 1;
  int cyc        = 0;
  int n_checks   = 0;
  int n_errors   = 0;
  bit cmp_on     = 1'b0;
  int start_cyc  [2];
  int done_cyc   [2];

  axi_lock_burst_client_if #(.CNT_W(CW)) bus_w ();
  axi_lock_burst_client_if #(.CNT_W(CW)) bus_r ();

  assign pend_in[0]      = arb_mode ? (owner != 0) : man_pend[0];
  assign pend_in[1]      = arb_mode ? (owner != 1) : man_pend[1];
  assign bus_w.pend_self = pend_in[0];
  assign bus_r.pend_self = pend_in[1];
  assign bus_w.beat_fire = bf[0];
  assign bus_r.beat_fire = bf[1];
  assign bus_w.burst_end = be[0];
  assign bus_r.burst_end = be[1];

  assign lock_req[0]    = bus_w.lock_req;
  assign lock_req[1]    = bus_r.lock_req;
  assign lock_done[0]   = bus_w.lock_done;
  assign lock_done[1]   = bus_r.lock_done;
  assign burst_start[0] = bus_w.burst_start;
  assign burst_start[1] = bus_r.burst_start;
  assign burst_len[0]   = bus_w.burst_len;
  assign burst_len[1]   = bus_r.burst_len;

  axi_lock_burst_client #(.BURST_LEN(BL), .CNT_W(CW)) dut_w (
    .clock(clock), .rst(rst), .enable(enable[0]), .flush(flush[0]),
    .fifo_level(fifo_level[0]), .bus(bus_w), .busy(busy[0]), .err(err[0])
  );

  axi_lock_burst_client #(.BURST_LEN(BL), .CNT_W(CW)) dut_r (
    .clock(clock), .rst(rst), .enable(enable[1]), .flush(flush[1]),
    .fifo_level(fifo_level[1]), .bus(bus_r), .busy(busy[1]), .err(err[1])
  );

  always @(posedge clock) cyc <= cyc + 1;

  // Arbiter: one owner at a time, released by lock_done, ties alternate starting with the write side.
  always @(posedge clock) begin
    if (rst) begin
      owner      <= -1;
      last_owner <= 1;
    end else if (owner >= 0) begin
      if ((owner == 0 && lock_done[0]) || (owner == 1 && lock_done[1])) owner <= -1;
    end else if (lock_req[0] && (!lock_req[1] || last_owner == 1)) begin
      owner      <= 0;
      last_owner <= 0;
    end else if (lock_req[1]) begin
      owner      <= 1;
      last_owner <= 1;
    end
  end

  // Reference model: phase of each requester, total beats seen, burst size and error flag.
  int m_ph    [2] = '{P_IDLE, P_IDLE};
  int m_beats [2] = '{0, 0};
  int m_len   [2] = '{0, 0};
  bit m_err   [2] = '{1'b0, 1'b0};

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ph[i] = P_IDLE; m_beats[i] = 0; m_len[i] = 0; m_err[i] = 1'b0;
      end else begin
        case (m_ph[i])
          P_IDLE: begin
            if (enable[i] && (int'(fifo_level[i]) >= BL || (flush[i] && fifo_level[i] != 0))) begin
              m_ph[i]  = P_REQ;
              m_len[i] = (int'(fifo_level[i]) < BL) ? int'(fifo_level[i]) : BL;
            end
          end
          P_REQ:   m_ph[i] = P_WAIT;
          P_WAIT:  if (!pend_in[i]) m_ph[i] = P_START;
          P_START: begin m_ph[i] = P_XFER; m_beats[i] = 0; end
          P_XFER: begin
            if (bf[i]) m_beats[i] = m_beats[i] + 1;
            if (m_beats[i] > m_len[i]) m_err[i] = 1'b1;
            if (be[i]) begin
              if (m_beats[i] != m_len[i]) m_err[i] = 1'b1;
              m_ph[i] = P_DONE;
            end
          end
          default: m_ph[i] = P_IDLE;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Compare process: every output of both instances, every cycle once reset has been applied.
  always @(negedge clock) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("lock_req%0d", i),    32'(lock_req[i]),    32'(m_ph[i] >= P_REQ && m_ph[i] <= P_XFER));
        check($sformatf("lock_done%0d", i),   32'(lock_done[i]),   32'(m_ph[i] == P_DONE));
        check($sformatf("burst_start%0d", i), 32'(burst_start[i]), 32'(m_ph[i] == P_START));
        check($sformatf("busy%0d", i),        32'(busy[i]),        32'(m_ph[i] != P_IDLE));
        check($sformatf("err%0d", i),         32'(err[i]),         32'(m_err[i]));
        check($sformatf("burst_len%0d", i),   32'(burst_len[i]),   32'(m_len[i]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Request a burst and advance to the first XFER cycle (requires pend_self low).
  task automatic start_burst(input int i, input int level, input bit fl);
    enable[i] = 1'b1; flush[i] = fl; fifo_level[i] = CW'(level);
    tick(1);
    enable[i] = 1'b0; flush[i] = 1'b0;
    tick(3);
  endtask

  task automatic send_beats(input int i, input int n, input bit end_on_last);
    for (int k = 0; k < n; k++) begin
      bf[i] = 1'b1;
      be[i] = end_on_last && (k == n - 1);
      tick(1);
    end
    bf[i] = 1'b0;
    if (!end_on_last) begin
      be[i] = 1'b1;
      tick(1);
    end
    be[i] = 1'b0;
  endtask

  task automatic drive_one(input int i);
    int k = 0;
    while (k < 200 && burst_start[i] !== 1'b1) begin
      tick(1);
      k++;
    end
    check($sformatf("arb_start_seen%0d", i), 32'(burst_start[i]), 32'd1);
    start_cyc[i] = cyc;
    tick(1);
    send_beats(i, BL, 1'b1);
    check($sformatf("arb_done%0d", i), 32'(lock_done[i]), 32'd1);
    done_cyc[i] = cyc;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arb_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      enable[i] = 1'b0; flush[i] = 1'b0; fifo_level[i] = '0;
      man_pend[i] = 1'b0; bf[i] = 1'b0; be[i] = 1'b0;
    end
    tick(1);
    cmp_on = 1'b1;
    tick(1);
    check("rst_lock_req", 32'(lock_req[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_burst_len", 32'(burst_len[0]), 32'd0);
    rst = 1'b0;

    // 1: full burst from a level above BURST_LEN.
    enable[0] = 1'b1; fifo_level[0] = 8'd20;
    tick(1);
    check("t1_req_after_1", 32'(lock_req[0]), 32'd1);
    check("t1_no_start_yet", 32'(burst_start[0]), 32'd0);
    enable[0] = 1'b0;
    tick(2);
    check("t1_start_after_3", 32'(burst_start[0]), 32'd1);
    check("t1_len16", 32'(burst_len[0]), 32'd16);
    tick(1);
    send_beats(0, 16, 1'b0);
    check("t1_done", 32'(lock_done[0]), 32'd1);
    check("t1_req_low_at_done", 32'(lock_req[0]), 32'd0);
    check("t1_err", 32'(err[0]), 32'd0);
    tick(1);
    check("t1_idle", 32'(busy[0]), 32'd0);

    // 2: flush partial burst, last beat together with burst_end; flush of empty FIFO and short level stay idle.
    start_burst(0, 5, 1'b1);
    check("t2_len5", 32'(burst_len[0]), 32'd5);
    send_beats(0, 5, 1'b1);
    check("t2_done", 32'(lock_done[0]), 32'd1);
    check("t2_err", 32'(err[0]), 32'd0);
    tick(1);
    enable[0] = 1'b1; flush[0] = 1'b1; fifo_level[0] = 8'd0;
    tick(4);
    check("t2_empty_flush_idle", 32'(busy[0]), 32'd0);
    flush[0] = 1'b0; fifo_level[0] = 8'd15;
    tick(4);
    check("t2_short_level_idle", 32'(busy[0]), 32'd0);
    enable[0] = 1'b0;

    // 3: grant held off by pend_self.
    man_pend[0] = 1'b1;
    enable[0] = 1'b1; fifo_level[0] = 8'd16;
    tick(1);
    enable[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("t3_held", 32'(burst_start[0]), 32'd0);
    end
    man_pend[0] = 1'b0;
    tick(1);
    check("t3_start_after_grant", 32'(burst_start[0]), 32'd1);
    tick(1);
    send_beats(0, 16, 1'b1);
    tick(1);

    // 4: short burst sets err, which stays set through a good burst; an extra beat sets it too.
    start_burst(0, 16, 1'b0);
    send_beats(0, 15, 1'b0);
    check("t4_short_err", 32'(err[0]), 32'd1);
    tick(1);
    start_burst(0, 16, 1'b0);
    send_beats(0, 16, 1'b1);
    check("t4_sticky", 32'(err[0]), 32'd1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t4_err_cleared", 32'(err[0]), 32'd0);
    bf[0] = 1'b1; be[0] = 1'b1;
    tick(3);
    bf[0] = 1'b0; be[0] = 1'b0;
    check("t4_stray_beats_ignored", 32'(err[0]), 32'd0);
    start_burst(0, 16, 1'b0);
    bf[0] = 1'b1;
    tick(16);
    check("t4_16_beats_ok", 32'(err[0]), 32'd0);
    tick(1);
    check("t4_17th_beat_err", 32'(err[0]), 32'd1);
    bf[0] = 1'b0; be[0] = 1'b1;
    tick(1);
    be[0] = 1'b0;
    check("t4_done_after_extra", 32'(lock_done[0]), 32'd1);
    tick(1);

    // 5: reset in the middle of a transfer.
    start_burst(0, 16, 1'b0);
    bf[0] = 1'b1;
    tick(7);
    bf[0] = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_req", 32'(lock_req[0]), 32'd0);
    check("t5_done", 32'(lock_done[0]), 32'd0);
    check("t5_busy", 32'(busy[0]), 32'd0);
    check("t5_len", 32'(burst_len[0]), 32'd0);
    check("t5_err", 32'(err[0]), 32'd0);
    tick(1);
    check("t5_no_late_done", 32'(lock_done[0]), 32'd0);

    // 6: both directions request together through the arbiter.
    arb_mode = 1'b1;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      enable[i] = 1'b1; fifo_level[i] = 8'd16;
    end
    tick(1);
    enable[0] = 1'b0; enable[1] = 1'b0;
    fork
      drive_one(0);
      drive_one(1);
    join
    check("t6_write_first", 32'(start_cyc[0] < start_cyc[1]), 32'd1);
    check("t6_read_after_write_done", 32'(done_cyc[0] < start_cyc[1]), 32'd1);
    tick(2);
    arb_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
